controle_exibicao: RTL and testbench

Sequencer that plays the stored colour sequence back on the 8 board LEDs before the player's turn. It walks the sequence memory from address 0 up to the current round index, lights one LED per entry for a difficulty-dependent on-time, and blanks the LEDs for a fixed gap between entries. It then pulses `pronto` so the game control unit can open the input phase. It sits between the game control unit, the sequence memory and the `leds` output mux.

---
 rtl/geogenius_pkg.sv | 31 +++
 rtl/contador_timer.sv | 26 ++
 rtl/controle_exibicao.sv | 157 +++++++++++++++
 tb/tb_controle_exibicao.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/geogenius_pkg.sv
// Shared definitions for the playback sequencer.
//   estado_t       : FSM state codes, also shown on the debug display
//   *_PADRAO       : default timing constants, in clock cycles
//   N_LEDS         : number of board LEDs
//   largura_timer  : timer width able to hold (largest constant - 1)
package geogenius_pkg;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        LIGA    = 4'd2,
        DESLIGA = 4'd3,
        FIM     = 4'd4
    } estado_t;

    localparam int T_LIGADO_FACIL_PADRAO   = 1000;
    localparam int T_LIGADO_DIFICIL_PADRAO = 500;
    localparam int T_DESLIGADO_PADRAO      = 250;
    localparam int N_LEDS                  = 8;

    // The timer only ever reaches T-1, so $clog2(T) bits suffice; at
    // least one bit is kept so the counter never collapses to zero width.
    function automatic int largura_timer(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/contador_timer.sv
// Up-counter used to time the LED on and blank intervals.
//   clock, reset : system clock, asynchronous active-low reset
//   limpar       : synchronous clear (wins over habilitar)
//   habilitar    : count enable
//   valor        : current count
module contador_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpar,
    input  logic         habilitar,
    output logic [W-1:0] valor
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (limpar) begin
            valor <= '0;
        end else if (habilitar) begin
            valor <= valor + 1'b1;
        end
    end

endmodule

// File: rtl/controle_exibicao.sv
// Plays the stored colour sequence back on the LEDs before the player's turn.
// Walks the sequence memory from address 0 to the latched round index,
// lighting one LED per entry, then blanking for a fixed gap, and finally
// pulses pronto for one cycle.
//   clock, reset  : system clock, asynchronous active-low reset
//   iniciar       : start playback (sampled in INICIAL only)
//   cancelar      : abort playback, highest priority
//   dificuldade   : on-time select, latched with iniciar
//   rodada        : index of last entry to show, latched with iniciar
//   dado_memoria  : LED index read combinationally at endereco
//   endereco      : sequence memory read address
//   leds          : one-hot LED drive (registered)
//   exibindo      : playback in progress
//   pronto        : one-cycle pulse on normal completion (registered)
//   db_estado     : state code for the debug display
module controle_exibicao
    import geogenius_pkg::*;
#(
    parameter int N_END            = 4,
    parameter int T_LIGADO_FACIL   = T_LIGADO_FACIL_PADRAO,
    parameter int T_LIGADO_DIFICIL = T_LIGADO_DIFICIL_PADRAO,
    parameter int T_DESLIGADO      = T_DESLIGADO_PADRAO
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic              dificuldade,
    input  logic [N_END-1:0]  rodada,
    input  logic [2:0]        dado_memoria,
    output logic [N_END-1:0]  endereco,
    output logic [N_LEDS-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int TW = largura_timer(T_LIGADO_FACIL, T_LIGADO_DIFICIL, T_DESLIGADO);
    localparam logic [TW-1:0] FIM_FACIL     = TW'(T_LIGADO_FACIL - 1);
    localparam logic [TW-1:0] FIM_DIFICIL   = TW'(T_LIGADO_DIFICIL - 1);
    localparam logic [TW-1:0] FIM_DESLIGADO = TW'(T_DESLIGADO - 1);

    estado_t           estado, prox_estado;
    logic [N_END-1:0]  ultimo, prox_ultimo, prox_endereco;
    logic              dif_r, prox_dif;
    logic [2:0]        cor_r, prox_cor;
    logic [TW-1:0]     tempo;
    logic              timer_limpar, timer_habilitar;
    logic              fim_ligado, fim_desligado;
    logic [N_LEDS-1:0] prox_leds;
    logic              prox_pronto;

    contador_timer #(.W(TW)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .limpar    (timer_limpar),
        .habilitar (timer_habilitar),
        .valor     (tempo)
    );

    assign fim_ligado    = (tempo == (dif_r ? FIM_DIFICIL : FIM_DESLIGADO_OR_FACIL()));
    assign fim_desligado = (tempo == FIM_DESLIGADO);

    function automatic logic [TW-1:0] FIM_DESLIGADO_OR_FACIL();
        return FIM_FACIL;
    endfunction

    always_comb begin
        prox_estado     = estado;
        prox_endereco   = endereco;
        prox_ultimo     = ultimo;
        prox_dif        = dif_r;
        prox_cor        = cor_r;
        timer_limpar    = 1'b0;
        timer_habilitar = 1'b0;

        if (cancelar) begin
            prox_estado   = INICIAL;
            prox_endereco = '0;
            timer_limpar  = 1'b1;
        end else begin
            case (estado)
                INICIAL: begin
                    timer_limpar = 1'b1;
                    if (iniciar) begin
                        prox_ultimo   = rodada;
                        prox_dif      = dificuldade;
                        prox_endereco = '0;
                        prox_estado   = PREPARA;
                    end
                end
                PREPARA: begin
                    prox_cor     = dado_memoria;
                    timer_limpar = 1'b1;
                    prox_estado  = LIGA;
                end
                LIGA: begin
                    if (fim_ligado) begin
                        timer_limpar = 1'b1;
                        prox_estado  = DESLIGA;
                    end else begin
                        timer_habilitar = 1'b1;
                    end
                end
                DESLIGA: begin
                    if (fim_desligado) begin
                        timer_limpar = 1'b1;
                        // Compare before incrementing so a full-range
                        // round never wraps the address.
                        if (endereco == ultimo) begin
                            prox_estado = FIM;
                        end else begin
                            prox_endereco = endereco + 1'b1;
                            prox_estado   = PREPARA;
                        end
                    end else begin
                        timer_habilitar = 1'b1;
                    end
                end
                FIM:     prox_estado = INICIAL;
                default: prox_estado = INICIAL;
            endcase
        end

        // Outputs are decoded from the next state so the registered
        // versions line up with the state they belong to.
        prox_leds = '0;
        if (prox_estado == LIGA) begin
            prox_leds[prox_cor] = 1'b1;
        end
        prox_pronto = (prox_estado == FIM);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= INICIAL;
            endereco <= '0;
            ultimo   <= '0;
            dif_r    <= 1'b0;
            cor_r    <= '0;
            leds     <= '0;
            pronto   <= 1'b0;
        end else begin
            estado   <= prox_estado;
            endereco <= prox_endereco;
            ultimo   <= prox_ultimo;
            dif_r    <= prox_dif;
            cor_r    <= prox_cor;
            leds     <= prox_leds;
            pronto   <= prox_pronto;
        end
    end

    assign exibindo  = (estado == PREPARA) || (estado == LIGA) || (estado == DESLIGA);
    assign db_estado = estado;

endmodule

// File: tb/tb_controle_exibicao.sv
module tb_controle_exibicao;

    localparam int N_END = 4;
    localparam int TF    = 4;
    localparam int TD_IF = 2;
    localparam int TOFF  = 2;
    localparam int W     = 8 + 1 + 1 + N_END + 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             iniciar = 1'b0;
    logic             cancelar = 1'b0;
    logic             dificuldade = 1'b0;
    logic [N_END-1:0] rodada = '0;
    logic [2:0]       dado_memoria;
    logic [N_END-1:0] endereco;
    logic [7:0]       leds;
    logic             exibindo;
    logic             pronto;
    logic [3:0]       db_estado;

    logic [2:0]   mem [16];
    logic [W-1:0] exp_q [$];
    int           vectors = 0;
    int           miscompares = 0;

    controle_exibicao #(
        .N_END            (N_END),
        .T_LIGADO_FACIL   (TF),
        .T_LIGADO_DIFICIL (TD_IF),
        .T_DESLIGADO      (TOFF)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .cancelar     (cancelar),
        .dificuldade  (dificuldade),
        .rodada       (rodada),
        .dado_memoria (dado_memoria),
        .endereco     (endereco),
        .leds         (leds),
        .exibindo     (exibindo),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    // clock / reset
    always #5 clock = ~clock;

    assign dado_memoria = mem[endereco];

    function automatic logic [W-1:0] pack(input logic [7:0] l, input logic e,
                                          input logic p, input int a, input int s);
        return {l, e, p, N_END'(a), 4'(s)};
    endfunction

    function automatic logic [W-1:0] idle(input int a);
        return pack(8'h00, 1'b0, 1'b0, a, 0);
    endfunction

    // Expected trace built from the timing rule: entry i spans cycles
    // i*P+1..(i+1)*P (one prepare cycle, ton lit cycles, TOFF blank cycles),
    // then the completion pulse in cycle k*P+1.
    task automatic push_playback(input int ult, input int ton);
        int p;
        int k;
        logic [7:0] l;
        p = 1 + ton + TOFF;
        k = ult + 1;
        for (int c = 1; c <= k * p; c++) begin
            int i;
            int off;
            i   = (c - 1) / p;
            off = (c - 1) % p;
            if (off == 0) begin
                exp_q.push_back(pack(8'h00, 1'b1, 1'b0, i, 1));
            end else if (off <= ton) begin
                l = 8'h00;
                l[mem[i]] = 1'b1;
                exp_q.push_back(pack(l, 1'b1, 1'b0, i, 2));
            end else begin
                exp_q.push_back(pack(8'h00, 1'b1, 1'b0, i, 3));
            end
        end
        exp_q.push_back(pack(8'h00, 1'b0, 1'b1, ult, 4));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_now(input logic [W-1:0] exp_v, input string tag);
        logic [W-1:0] obs;
        obs = {leds, exibindo, pronto, endereco, db_estado};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed leds/exib/pronto/end/estado=%h expected %h",
                   tag, obs, exp_v);
        end
    endtask

    task automatic check_pop(input string tag);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: expected queue empty, observed %h", tag,
                   {leds, exibindo, pronto, endereco, db_estado});
        end else begin
            check_now(exp_q.pop_front(), tag);
        end
    endtask

    task automatic play(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            check_pop($sformatf("%s_c%0d", tag, c + 1));
            tick();
        end
    endtask

    task automatic start(input int r, input logic d);
        rodada      = N_END'(r);
        dificuldade = d;
        iniciar     = 1'b1;
        tick();
        iniciar     = 1'b0;
    endtask

    initial begin
        mem[0] = 3'd3;
        mem[1] = 3'd0;
        mem[2] = 3'd7;
        mem[3] = 3'd5;
        for (int i = 4; i < 16; i++) mem[i] = 3'($urandom_range(0, 7));

        // reset values
        #1;
        check_now(idle(0), "reset_hold");
        tick();
        tick();
        check_now(idle(0), "reset_hold2");
        reset = 1'b1;
        tick();
        check_now(idle(0), "after_reset");

        // asynchronous reset in the middle of LIGA
        start(0, 1'b0);
        push_playback(0, TF);
        play(2, "pre_reset");
        check_pop("pre_reset_liga");
        #2 reset = 1'b0;
        #1 check_now(idle(0), "reset_async");
        exp_q.delete();
        tick();
        check_now(idle(0), "reset_low_edge");
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_now(idle(0), "reset_release_idle");
        end

        // single entry, easy timing
        start(0, 1'b0);
        push_playback(0, TF);
        play(exp_q.size(), "r0_easy");
        check_now(idle(0), "r0_easy_idle");

        // four entries, hard timing
        start(3, 1'b1);
        push_playback(3, TD_IF);
        play(exp_q.size(), "r3_hard");
        check_now(idle(3), "r3_hard_idle");

        // inputs changed after acceptance have no effect
        start(2, 1'b0);
        push_playback(2, TF);
        play(2, "r2_latch");
        dificuldade = 1'b1;
        rodada      = '0;
        play(exp_q.size(), "r2_latch");
        check_now(idle(2), "r2_latch_idle");
        dificuldade = 1'b0;

        // cancel during cycle 9
        start(3, 1'b1);
        push_playback(3, TD_IF);
        play(8, "cancel");
        check_pop("cancel_c9");
        cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 25; c++) begin
            check_now(idle(0), $sformatf("cancel_idle_%0d", c));
            tick();
        end

        // iniciar held high: back-to-back playbacks every 9 cycles
        rodada      = '0;
        dificuldade = 1'b0;
        iniciar     = 1'b1;
        tick();
        push_playback(0, TF);
        exp_q.push_back(idle(0));
        push_playback(0, TF);
        exp_q.push_back(idle(0));
        play(exp_q.size() - 1, "held");
        check_pop("held_last");
        iniciar = 1'b0;
        tick();
        check_now(idle(0), "held_stop");

        // full range: every entry, address must not wrap
        start(15, 1'b1);
        push_playback(15, TD_IF);
        play(exp_q.size(), "full");
        check_now(idle(15), "full_idle");
        tick();
        check_now(idle(15), "full_idle2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
